// File: rtl/acc_icb_arbiter.sv
// Round-robin arbiter that funnels N_REQ requester ICB ports onto one downstream
// ICB port, allowing a single transaction in flight at a time.
module acc_icb_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_icb_cmd_valid,
  output logic [N_REQ-1:0]          req_icb_cmd_ready,
  input  logic [N_REQ-1:0]          req_icb_cmd_read,
  input  logic [N_REQ*AW-1:0]       req_icb_cmd_addr,
  input  logic [N_REQ*DW-1:0]       req_icb_cmd_wdata,
  input  logic [N_REQ*(DW/8)-1:0]   req_icb_cmd_wmask,
  output logic [N_REQ-1:0]          req_icb_rsp_valid,
  input  logic [N_REQ-1:0]          req_icb_rsp_ready,
  output logic [DW-1:0]             req_icb_rsp_rdata,
  output logic                      req_icb_rsp_err,
  output logic                      acc_icb_cmd_valid,
  input  logic                      acc_icb_cmd_ready,
  output logic                      acc_icb_cmd_read,
  output logic [AW-1:0]             acc_icb_cmd_addr,
  output logic [DW-1:0]             acc_icb_cmd_wdata,
  output logic [DW/8-1:0]           acc_icb_cmd_wmask,
  input  logic                      acc_icb_rsp_valid,
  output logic                      acc_icb_rsp_ready,
  input  logic [DW-1:0]             acc_icb_rsp_rdata,
  input  logic                      acc_icb_rsp_err,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] rr_pick;
  logic          rr_hit;
  logic [IW-1:0] next_ptr;
  logic          gnt_cmd_valid;
  logic          gnt_rsp_ready;
  int            rr_idx;

  // Search starts at ptr and wraps, so the last-served requester goes to the back.
  always_comb begin
    rr_pick = '0;
    rr_hit  = 1'b0;
    rr_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = int'(ptr) + k;
      if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
      if (!rr_hit && req_icb_cmd_valid[rr_idx]) begin
        rr_hit  = 1'b1;
        rr_pick = IW'(rr_idx);
      end
    end
  end

  assign next_ptr      = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign gnt_cmd_valid = req_icb_cmd_valid[grant_id];
  assign gnt_rsp_ready = req_icb_rsp_ready[grant_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_hit) begin
            grant_id <= rr_pick;
            state    <= CMD;
            busy     <= 1'b1;
          end
        end
        CMD: begin
          // A requester withdrawing its command abandons the grant without advancing ptr.
          if (!gnt_cmd_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (acc_icb_cmd_ready) begin
            state <= RSP;
          end
        end
        RSP: begin
          if (acc_icb_rsp_valid && gnt_rsp_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= next_ptr;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    acc_icb_cmd_valid = 1'b0;
    acc_icb_cmd_read  = 1'b0;
    acc_icb_cmd_addr  = '0;
    acc_icb_cmd_wdata = '0;
    acc_icb_cmd_wmask = '0;
    req_icb_cmd_ready = '0;
    req_icb_rsp_valid = '0;
    acc_icb_rsp_ready = 1'b0;
    req_icb_rsp_rdata = '0;
    req_icb_rsp_err   = 1'b0;
    if (state == CMD) begin
      acc_icb_cmd_valid           = gnt_cmd_valid;
      acc_icb_cmd_read            = req_icb_cmd_read[grant_id];
      acc_icb_cmd_addr            = req_icb_cmd_addr[grant_id*AW +: AW];
      acc_icb_cmd_wdata           = req_icb_cmd_wdata[grant_id*DW +: DW];
      acc_icb_cmd_wmask           = req_icb_cmd_wmask[grant_id*MW +: MW];
      req_icb_cmd_ready[grant_id] = acc_icb_cmd_ready;
    end
    // Responses arriving outside RSP are left stalled rather than forwarded.
    if (state == RSP) begin
      req_icb_rsp_valid[grant_id] = acc_icb_rsp_valid;
      acc_icb_rsp_ready           = gnt_rsp_ready;
      req_icb_rsp_rdata           = acc_icb_rsp_rdata;
      req_icb_rsp_err             = acc_icb_rsp_err;
    end
  end

endmodule

// File: tb/tb_acc_icb_arbiter.sv
// Directed bench for acc_icb_arbiter: stimulus queues expected downstream commands
// and requester responses; a negedge monitor pops and compares on each handshake.
module tb_acc_icb_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_icb_cmd_valid;
  logic [N-1:0]      req_icb_cmd_ready;
  logic [N-1:0]      req_icb_cmd_read;
  logic [N*AW-1:0]   req_icb_cmd_addr;
  logic [N*DW-1:0]   req_icb_cmd_wdata;
  logic [N*MW-1:0]   req_icb_cmd_wmask;
  logic [N-1:0]      req_icb_rsp_valid;
  logic [N-1:0]      req_icb_rsp_ready;
  logic [DW-1:0]     req_icb_rsp_rdata;
  logic              req_icb_rsp_err;
  logic              acc_icb_cmd_valid;
  logic              acc_icb_cmd_ready;
  logic              acc_icb_cmd_read;
  logic [AW-1:0]     acc_icb_cmd_addr;
  logic [DW-1:0]     acc_icb_cmd_wdata;
  logic [MW-1:0]     acc_icb_cmd_wmask;
  logic              acc_icb_rsp_valid;
  logic              acc_icb_rsp_ready;
  logic [DW-1:0]     acc_icb_rsp_rdata;
  logic              acc_icb_rsp_err;
  logic [1:0]        grant_id;
  logic              busy;

  acc_icb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_icb_cmd_valid (req_icb_cmd_valid),
    .req_icb_cmd_ready (req_icb_cmd_ready),
    .req_icb_cmd_read  (req_icb_cmd_read),
    .req_icb_cmd_addr  (req_icb_cmd_addr),
    .req_icb_cmd_wdata (req_icb_cmd_wdata),
    .req_icb_cmd_wmask (req_icb_cmd_wmask),
    .req_icb_rsp_valid (req_icb_rsp_valid),
    .req_icb_rsp_ready (req_icb_rsp_ready),
    .req_icb_rsp_rdata (req_icb_rsp_rdata),
    .req_icb_rsp_err   (req_icb_rsp_err),
    .acc_icb_cmd_valid (acc_icb_cmd_valid),
    .acc_icb_cmd_ready (acc_icb_cmd_ready),
    .acc_icb_cmd_read  (acc_icb_cmd_read),
    .acc_icb_cmd_addr  (acc_icb_cmd_addr),
    .acc_icb_cmd_wdata (acc_icb_cmd_wdata),
    .acc_icb_cmd_wmask (acc_icb_cmd_wmask),
    .acc_icb_rsp_valid (acc_icb_rsp_valid),
    .acc_icb_rsp_ready (acc_icb_rsp_ready),
    .acc_icb_rsp_rdata (acc_icb_rsp_rdata),
    .acc_icb_rsp_err   (acc_icb_rsp_err),
    .grant_id          (grant_id),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } cmd_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  cmd_t mon_cmd;
  rsp_t mon_rsp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cycles;

  function automatic void check_output(input string name, input logic [63:0] act,
                                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void expect_cmd(input int id, input logic rd, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] m);
    cmd_t c;
    c.id = id; c.rd = rd; c.addr = a; c.wdata = d; c.mask = m;
    cmd_q.push_back(c);
  endfunction

  function automatic void expect_rsp(input int id, input logic [31:0] d, input logic e);
    rsp_t r;
    r.id = id; r.rdata = d; r.err = e;
    rsp_q.push_back(r);
  endfunction

  // Monitor: every completed handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (acc_icb_cmd_valid && acc_icb_cmd_ready) begin
        if (cmd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_cmd: got grant %0d, expected no command", grant_id);
        end else begin
          mon_cmd = cmd_q.pop_front();
          check_output("cmd_grant", 64'(grant_id), 64'(mon_cmd.id));
          check_output("cmd_read",  64'(acc_icb_cmd_read), 64'(mon_cmd.rd));
          check_output("cmd_addr",  64'(acc_icb_cmd_addr), 64'(mon_cmd.addr));
          check_output("cmd_wdata", 64'(acc_icb_cmd_wdata), 64'(mon_cmd.wdata));
          check_output("cmd_wmask", 64'(acc_icb_cmd_wmask), 64'(mon_cmd.mask));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_icb_rsp_valid[i] && req_icb_rsp_ready[i]) begin
          if (rsp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_rsp: got port %0d, expected no response", i);
          end else begin
            mon_rsp = rsp_q.pop_front();
            check_output("rsp_port",  64'(i), 64'(mon_rsp.id));
            check_output("rsp_rdata", 64'(req_icb_rsp_rdata), 64'(mon_rsp.rdata));
            check_output("rsp_err",   64'(req_icb_rsp_err), 64'(mon_rsp.err));
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input int i, input logic v, input logic rd, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] m);
    req_icb_cmd_valid[i]          = v;
    req_icb_cmd_read[i]           = rd;
    req_icb_cmd_addr[i*AW +: AW]  = a;
    req_icb_cmd_wdata[i*DW +: DW] = d;
    req_icb_cmd_wmask[i*MW +: MW] = m;
  endtask

  task automatic clear_all();
    req_icb_cmd_valid = '0;
    req_icb_cmd_read  = '0;
    req_icb_cmd_addr  = '0;
    req_icb_cmd_wdata = '0;
    req_icb_cmd_wmask = '0;
    req_icb_rsp_ready = '0;
    acc_icb_cmd_ready = 1'b0;
    acc_icb_rsp_valid = 1'b0;
    acc_icb_rsp_rdata = '0;
    acc_icb_rsp_err   = 1'b0;
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with busy-looking inputs: every output must still read zero.
    clear_all();
    rst_n = 1'b0;
    req_icb_cmd_valid = '1;
    req_icb_rsp_ready = '1;
    acc_icb_cmd_ready = 1'b1;
    acc_icb_rsp_valid = 1'b1;
    acc_icb_rsp_rdata = 32'hFFFF_FFFF;
    acc_icb_rsp_err   = 1'b1;
    cycle();
    cycle();
    check_output("rst_busy",          64'(busy), 64'd0);
    check_output("rst_grant_id",      64'(grant_id), 64'd0);
    check_output("rst_acc_cmd_valid", 64'(acc_icb_cmd_valid), 64'd0);
    check_output("rst_cmd_ready",     64'(req_icb_cmd_ready), 64'd0);
    check_output("rst_rsp_valid",     64'(req_icb_rsp_valid), 64'd0);
    check_output("rst_acc_rsp_ready", 64'(acc_icb_rsp_ready), 64'd0);
    check_output("rst_rsp_rdata",     64'(req_icb_rsp_rdata), 64'd0);
    check_output("rst_rsp_err",       64'(req_icb_rsp_err), 64'd0);
    clear_all();
    rst_n = 1'b1;

    // Single write from requester 1.
    apply_stimulus(1, 1'b1, 1'b0, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF);
    acc_icb_cmd_ready = 1'b1;
    req_icb_rsp_ready = '1;
    expect_cmd(1, 1'b0, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF);
    expect_rsp(1, 32'h55AA_55AA, 1'b0);
    settle();
    check_output("a_no_early_valid", 64'(acc_icb_cmd_valid), 64'd0);
    check_output("a_idle_busy",      64'(busy), 64'd0);
    cycle();
    settle();
    check_output("a_grant_id",  64'(grant_id), 64'd1);
    check_output("a_busy",      64'(busy), 64'd1);
    check_output("a_cmd_ready", 64'(req_icb_cmd_ready), 64'b010);
    cycle();
    apply_stimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    acc_icb_rsp_valid = 1'b1;
    acc_icb_rsp_rdata = 32'h55AA_55AA;
    settle();
    check_output("a_rsp_valid", 64'(req_icb_rsp_valid), 64'b010);
    check_output("a_addr_zero", 64'(acc_icb_cmd_addr), 64'd0);
    cycle();
    acc_icb_rsp_valid = 1'b0;
    settle();
    check_output("a_back_idle",  64'(busy), 64'd0);
    check_output("a_grant_hold", 64'(grant_id), 64'd1);

    // All three requesters continuously valid: grants 0,1,2,0,1.
    cycle();
    do_reset();
    for (int i = 0; i < N; i++)
      apply_stimulus(i, 1'b1, (i == 1), 32'h2000_0000 + 32'(i * 4), 32'hA0 + 32'(i), 4'(1 << i));
    acc_icb_cmd_ready = 1'b1;
    acc_icb_rsp_valid = 1'b1;
    acc_icb_rsp_rdata = 32'hC0DE_0000;
    req_icb_rsp_ready = '1;
    for (int t = 0; t < 5; t++) begin
      expect_cmd(t % 3, ((t % 3) == 1), 32'h2000_0000 + 32'((t % 3) * 4), 32'hA0 + 32'(t % 3),
                 4'(1 << (t % 3)));
      expect_rsp(t % 3, 32'hC0DE_0000, 1'b0);
    end
    busy_cycles = 0;
    repeat (15) begin
      settle();
      if (busy) busy_cycles++;
      cycle();
    end
    clear_all();
    check_output("b_busy_cycles",  64'(busy_cycles), 64'd10);
    check_output("b_cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    check_output("b_rsp_q_drained", 64'(rsp_q.size()), 64'd0);

    // Downstream holds cmd_ready low for five cycles.
    cycle();
    do_reset();
    apply_stimulus(0, 1'b1, 1'b0, 32'h3000_0010, 32'h0123_4567, 4'h3);
    apply_stimulus(2, 1'b1, 1'b1, 32'h3000_0020, 32'h89AB_CDEF, 4'hC);
    req_icb_rsp_ready = '1;
    expect_cmd(0, 1'b0, 32'h3000_0010, 32'h0123_4567, 4'h3);
    expect_rsp(0, 32'h1111_2222, 1'b0);
    cycle();
    repeat (5) begin
      settle();
      check_output("c_grant",     64'(grant_id), 64'd0);
      check_output("c_addr",      64'(acc_icb_cmd_addr), 64'h3000_0010);
      check_output("c_wdata",     64'(acc_icb_cmd_wdata), 64'h0123_4567);
      check_output("c_cmd_ready", 64'(req_icb_cmd_ready), 64'd0);
      check_output("c_cmd_valid", 64'(acc_icb_cmd_valid), 64'd1);
      cycle();
    end
    acc_icb_cmd_ready = 1'b1;
    settle();
    check_output("c_ready_hs", 64'(req_icb_cmd_ready), 64'b001);
    cycle();
    apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    apply_stimulus(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    acc_icb_rsp_valid = 1'b1;
    acc_icb_rsp_rdata = 32'h1111_2222;
    settle();
    cycle();
    acc_icb_rsp_valid = 1'b0;

    // Requester 2 read with error response and a stalled response ready.
    apply_stimulus(2, 1'b1, 1'b1, 32'h4000_0080, 32'h0, 4'h0);
    acc_icb_cmd_ready = 1'b1;
    req_icb_rsp_ready = 3'b011;
    expect_cmd(2, 1'b1, 32'h4000_0080, 32'h0, 4'h0);
    cycle();
    settle();
    cycle();
    apply_stimulus(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    acc_icb_rsp_valid = 1'b1;
    acc_icb_rsp_rdata = 32'h1234_5678;
    acc_icb_rsp_err   = 1'b1;
    repeat (3) begin
      settle();
      check_output("d_acc_rsp_ready", 64'(acc_icb_rsp_ready), 64'd0);
      check_output("d_rsp_valid",     64'(req_icb_rsp_valid), 64'b100);
      check_output("d_rdata",         64'(req_icb_rsp_rdata), 64'h1234_5678);
      check_output("d_err",           64'(req_icb_rsp_err), 64'd1);
      cycle();
    end
    req_icb_rsp_ready = 3'b111;
    expect_rsp(2, 32'h1234_5678, 1'b1);
    settle();
    cycle();
    acc_icb_rsp_valid = 1'b0;
    acc_icb_rsp_err   = 1'b0;
    settle();
    check_output("d_idle", 64'(busy), 64'd0);

    // Requester 0 withdraws before the handshake; ptr must stay at 0.
    cycle();
    apply_stimulus(0, 1'b1, 1'b0, 32'h5000_0000, 32'h5, 4'h1);
    apply_stimulus(1, 1'b1, 1'b0, 32'h5100_0000, 32'h6, 4'h2);
    acc_icb_cmd_ready = 1'b0;
    cycle();
    settle();
    check_output("e_grant", 64'(grant_id), 64'd0);
    cycle();
    apply_stimulus(0, 1'b0, 1'b0, 32'h5000_0000, 32'h5, 4'h1);
    acc_icb_cmd_ready = 1'b1;
    settle();
    check_output("e_cmd_valid_drop", 64'(acc_icb_cmd_valid), 64'd0);
    check_output("e_busy_still",     64'(busy), 64'd1);
    cycle();
    apply_stimulus(0, 1'b1, 1'b0, 32'h5000_0000, 32'h5, 4'h1);
    req_icb_rsp_ready = '1;
    expect_cmd(0, 1'b0, 32'h5000_0000, 32'h5, 4'h1);
    expect_rsp(0, 32'h7777_7777, 1'b0);
    settle();
    check_output("e_idle", 64'(busy), 64'd0);
    cycle();
    settle();
    check_output("e_regrant", 64'(grant_id), 64'd0);
    cycle();
    apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    apply_stimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    acc_icb_rsp_valid = 1'b1;
    acc_icb_rsp_rdata = 32'h7777_7777;
    settle();
    cycle();
    acc_icb_rsp_valid = 1'b0;

    // Asynchronous reset while a response is pending to requester 2.
    apply_stimulus(2, 1'b1, 1'b1, 32'h6000_0000, 32'h0, 4'h0);
    acc_icb_cmd_ready = 1'b1;
    req_icb_rsp_ready = '0;
    expect_cmd(2, 1'b1, 32'h6000_0000, 32'h0, 4'h0);
    cycle();
    settle();
    cycle();
    apply_stimulus(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    acc_icb_rsp_valid = 1'b1;
    acc_icb_rsp_rdata = 32'hCAFE_F00D;
    acc_icb_rsp_err   = 1'b1;
    #1;
    check_output("f_pre_rsp_valid", 64'(req_icb_rsp_valid), 64'b100);
    check_output("f_pre_rdata",     64'(req_icb_rsp_rdata), 64'hCAFE_F00D);
    check_output("f_pre_grant",     64'(grant_id), 64'd2);
    rst_n = 1'b0;
    #1;
    check_output("f_rst_rsp_valid", 64'(req_icb_rsp_valid), 64'd0);
    check_output("f_rst_rdata",     64'(req_icb_rsp_rdata), 64'd0);
    check_output("f_rst_err",       64'(req_icb_rsp_err), 64'd0);
    check_output("f_rst_busy",      64'(busy), 64'd0);
    check_output("f_rst_grant",     64'(grant_id), 64'd0);
    check_output("f_rst_cmd_valid", 64'(acc_icb_cmd_valid), 64'd0);
    cycle();
    clear_all();
    rst_n = 1'b1;
    apply_stimulus(1, 1'b1, 1'b0, 32'h7000_0004, 32'hBEEF_0001, 4'h6);
    acc_icb_cmd_ready = 1'b1;
    req_icb_rsp_ready = '1;
    expect_cmd(1, 1'b0, 32'h7000_0004, 32'hBEEF_0001, 4'h6);
    expect_rsp(1, 32'h0000_0099, 1'b0);
    cycle();
    settle();
    check_output("f_grant", 64'(grant_id), 64'd1);
    cycle();
    apply_stimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    acc_icb_rsp_valid = 1'b1;
    acc_icb_rsp_rdata = 32'h0000_0099;
    settle();
    cycle();
    acc_icb_rsp_valid = 1'b0;
    settle();

    check_output("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check_output("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
